pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage core. Drives enable/bubble controls of IF_ID, ID_EX, EX_MEM and MEM_WB and the PC write-enable.
- Resolves the following per cycle, with a registered FSM for multi-cycle conditions:
  - load-use hazards
  - EX-stage branch/jump redirects
  - data-memory wait states (with timeout)
  - external debug pause
- Also keeps saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for a 5-stage pipeline. Resolves the
//            following hazards:
//              - memory wait, with a timeout
//              - debug pause
//              - EX redirect
//              - load-use
//            It also keeps saturating stall and flush performance counters.
// Ports    : clk, rst (sync, active-low)
//            ID/EX hazard info     : id_rs1_i, id_rs2_i, id_use_rs1_i,
//                                    id_use_rs2_i, ex_rd_i, ex_mem_read_i
//            Redirect / mem / debug: ex_redirect_i, mem_req_i, mem_ack_i,
//                                    pause_req_i
//            Pipeline controls     : pc_stall_o, if_id_stall_o, if_id_flush_o,
//                                    id_ex_stall_o, id_ex_flush_o,
//                                    ex_mem_stall_o, mem_wb_flush_o,
//                                    pc_redirect_o, pause_ack_o
//            Status                : mem_err_o, stall_cnt_o, flush_cnt_o
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TMO_W   = 8,
  parameter int MEM_TMO = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  input  logic             pause_req_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_flush_o,
  output logic             pc_redirect_o,
  output logic             pause_ack_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_PAUSE    = 2'd2;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_busy, load_use, tmo_hit;
  logic full_stall, pause_hold, eval_run;

  assign mem_busy = mem_req_i & ~mem_ack_i;
  // x0 is never a real destination, so it cannot create a dependency.
  assign load_use = ex_mem_read_i & (ex_rd_i != 5'd0) &
                    ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                     (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
  assign tmo_hit  = (tmo_q == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_RUN;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (mem_busy)                         state_d = S_MEM_WAIT;
        else if (pause_req_i & ~ex_redirect_i) state_d = S_PAUSE;
      end
      S_MEM_WAIT: begin
        // A pause request is deliberately not honoured on the release cycle.
        if (!mem_busy || tmo_hit) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (mem_busy)          state_d = S_MEM_WAIT;
        else if (!pause_req_i) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Output logic. The release cycle of MEM_WAIT (ack or timeout) and the
  // exit cycle of PAUSE both evaluate redirect/load-use as in RUN.
  always_comb begin
    full_stall = 1'b0;
    pause_hold = 1'b0;
    eval_run   = 1'b0;
    case (state_q)
      S_RUN: begin
        full_stall = mem_busy;
        eval_run   = ~mem_busy;
      end
      S_MEM_WAIT: begin
        full_stall = mem_busy & ~tmo_hit;
        eval_run   = ~full_stall;
      end
      S_PAUSE: begin
        full_stall = mem_busy;
        pause_hold = ~mem_busy & pause_req_i;
        eval_run   = ~mem_busy & ~pause_req_i;
      end
      default: eval_run = 1'b0;
    endcase

    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    pc_redirect_o  = 1'b0;
    pause_ack_o    = 1'b0;

    if (!rst) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else if (full_stall) begin
      // Freeze everything up to MEM and drain a bubble into WB.
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else if (pause_hold) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_stall_o  = 1'b1;
      ex_mem_stall_o = 1'b1;
      pause_ack_o    = 1'b1;
    end else if (eval_run && ex_redirect_i) begin
      // The load-use consumer is on the wrong path, so redirect wins.
      pc_redirect_o  = 1'b1;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
    end else if (eval_run && load_use) begin
      pc_stall_o     = 1'b1;
      if_id_stall_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
    end
  end

  // Timeout, sticky error and performance counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      tmo_q <= (state_q == S_MEM_WAIT) ? tmo_q + 1'b1 : '0;
      if ((state_q == S_MEM_WAIT) && mem_busy && tmo_hit) mem_err_q <= 1'b1;
      if (pc_stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (pc_redirect_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire
